alu_issuer: RTL
===============

ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 Parameter TIMEOUT, default 64: number of BUSY cycles without AluWe before the operation is aborted (legal range 2..65535).
REQ-002 Port Clk  input  1: the single clock; all state updates on the rising edge.
REQ-003 Port Reset  input  1: asynchronous, active-low reset.
REQ-004 Port ReqValid  input  1: an operation request is presented.
REQ-005 Port ReqReady  output  1: the issuer accepts a request this cycle.
REQ-006 Ports ReqA, ReqB  input  32 each: operands.
REQ-007 Port ReqOp  input  3: ALU opcode (7 = MOD).
REQ-008 Ports AluA, AluB  output  32 each: operands driven to the ALU.
REQ-009 Port AluOp  output  3: opcode driven to the ALU.
REQ-010 Port AluReq  output  1: high while an operation is outstanding at the ALU.
REQ-011 Port AluWe  input  1: single-cycle pulse from the ALU marking a valid result.
REQ-012 Ports AluResult  input  32, and AluZ, AluV, AluC  input  1 each: ALU result and flags.
REQ-013 Port RspValid  output  1: a response is held.
REQ-014 Port RspReady  input  1: the consumer takes the response.
REQ-015 Port RspResult  output  32: captured result.
REQ-016 Ports RspZ, RspV, RspC  output  1 each: captured flags.
REQ-017 Port RspErr  output  1: the operation timed out.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-019 IDLE: ReqReady=1; on a rising edge with ReqValid=1, ReqA/ReqB/ReqOp SHALL be latched into AluA/AluB/AluOp and the state SHALL move to BUSY.
REQ-020 BUSY: AluReq=1 and ReqReady=0; AluA, AluB and AluOp SHALL stay stable until BUSY is left.
REQ-021 BUSY with AluWe=1 at an edge: AluResult/Z/V/C SHALL be captured into Rsp*, RspErr SHALL be set to 0, and the state SHALL move to RESP.
REQ-022 The timeout counter SHALL clear on entry to BUSY and increment on each BUSY cycle without AluWe.
REQ-023 When the counter reaches TIMEOUT-1 without AluWe: RspResult SHALL be 0, RspZ/V/C SHALL be 0, RspErr SHALL be 1, and the state SHALL move to RESP.
REQ-024 If AluWe and timeout occur on the same edge, AluWe SHALL win.
REQ-025 RESP: RspValid=1 and Rsp* SHALL be held stable; on an edge with RspReady=1 the state SHALL move to IDLE.
REQ-026 AluWe SHALL be ignored in IDLE and RESP, with no state or data change.
REQ-027 Latency: request accepted at edge N gives AluReq=1 from N+1; AluWe sampled at edge M gives RspValid=1 from M+1.
REQ-028 Minimum request-to-request spacing SHALL be 3 cycles (accept, BUSY ≥1, RESP ≥1).
REQ-029 All outputs SHALL be registered; ReqReady, AluReq and RspValid SHALL be decoded directly from the state register.

Reset
REQ-030 Reset low SHALL immediately force IDLE, independent of Clk.
REQ-031 During reset, AluA=AluB=0, AluOp=0, AluReq=0, RspValid=0, RspResult=0, RspZ=RspV=RspC=RspErr=0, and the counter SHALL be 0.
REQ-032 Reset during BUSY or RESP SHALL discard the operation; a later AluWe SHALL be ignored.
REQ-033 ReqReady SHALL be 1 on the first cycle after Reset is deasserted.

Configuration
REQ-034 With macro ALU_ISSUER_TIMEOUT_EN defined, the timeout counter and the REQ-022..024 behaviour SHALL be present.
REQ-035 With ALU_ISSUER_TIMEOUT_EN undefined, there SHALL be no counter, BUSY SHALL wait indefinitely for AluWe, RspErr SHALL be tied to 0, and TIMEOUT SHALL be ignored.

Verification
REQ-036 Request A=16, B=5, Op=7; AluWe with AluResult=1 three cycles later -> RspValid=1, RspResult=1, RspErr=0, AluReq=0.
REQ-037 Request A=0, B=0, Op=2; AluWe with AluResult=0, AluZ=1 -> RspZ=1; hold RspReady=0 for 5 cycles -> Rsp* stable, ReqReady=0 throughout.
REQ-038 Timeout enabled, TIMEOUT=8, no AluWe -> RspValid rises exactly 8 cycles after AluReq rises, with RspErr=1 and RspResult=0.
REQ-039 Reset pulled low in BUSY, then AluWe pulsed after release -> RspValid stays 0, ReqReady=1.
REQ-040 Back-to-back requests with RspReady tied to 1 -> each accepted only in IDLE, responses in order, spacing ≥3 cycles, and a spurious AluWe in IDLE causes no response.

Source files
------------

// File: rtl/alu_issuer.sv
// Issues one ALU operation at a time and holds the result until the consumer takes it.
// The optional BUSY timeout is built only when ALU_ISSUER_TIMEOUT_EN is defined.
module alu_issuer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [31:0] ReqA,
    input  logic [31:0] ReqB,
    input  logic [2:0]  ReqOp,
    output logic [31:0] AluA,
    output logic [31:0] AluB,
    output logic [2:0]  AluOp,
    output logic        AluReq,
    input  logic        AluWe,
    input  logic [31:0] AluResult,
    input  logic        AluZ,
    input  logic        AluV,
    input  logic        AluC,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] RspResult,
    output logic        RspZ,
    output logic        RspV,
    output logic        RspC,
    output logic        RspErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] alu_a_q;
    logic [31:0] alu_b_q;
    logic [2:0]  alu_op_q;
    logic [31:0] rsp_result_q;
    logic        rsp_z_q;
    logic        rsp_v_q;
    logic        rsp_c_q;

`ifdef ALU_ISSUER_TIMEOUT_EN
    // BUSY lasts at most TIMEOUT cycles: the abort edge is the one where the count reads TIMEOUT-1.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
    logic [15:0] cnt_q;
    logic        rsp_err_q;
`else
    localparam int unsigned unused_timeout = TIMEOUT;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_result_q <= '0;
            rsp_z_q      <= 1'b0;
            rsp_v_q      <= 1'b0;
            rsp_c_q      <= 1'b0;
`ifdef ALU_ISSUER_TIMEOUT_EN
            cnt_q        <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (ReqValid) begin
                        alu_a_q  <= ReqA;
                        alu_b_q  <= ReqB;
                        alu_op_q <= ReqOp;
                        state_q  <= BUSY;
`ifdef ALU_ISSUER_TIMEOUT_EN
                        cnt_q    <= '0;
`endif
                    end
                end
                BUSY: begin
                    // A result arriving on the abort edge takes priority over the timeout.
                    if (AluWe) begin
                        rsp_result_q <= AluResult;
                        rsp_z_q      <= AluZ;
                        rsp_v_q      <= AluV;
                        rsp_c_q      <= AluC;
                        state_q      <= RESP;
`ifdef ALU_ISSUER_TIMEOUT_EN
                        rsp_err_q    <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_result_q <= '0;
                        rsp_z_q      <= 1'b0;
                        rsp_v_q      <= 1'b0;
                        rsp_c_q      <= 1'b0;
                        rsp_err_q    <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cnt_q        <= cnt_q + 16'd1;
`endif
                    end
                end
                RESP: begin
                    if (RspReady) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ReqReady  = (state_q == IDLE);
    assign AluReq    = (state_q == BUSY);
    assign RspValid  = (state_q == RESP);
    assign AluA      = alu_a_q;
    assign AluB      = alu_b_q;
    assign AluOp     = alu_op_q;
    assign RspResult = rsp_result_q;
    assign RspZ      = rsp_z_q;
    assign RspV      = rsp_v_q;
    assign RspC      = rsp_c_q;
`ifdef ALU_ISSUER_TIMEOUT_EN
    assign RspErr    = rsp_err_q;
`else
    assign RspErr    = 1'b0;
`endif

endmodule
